// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single-port RAM with starvation forcing for port 1
module mem_arbiter #(
  parameter int A        = 12,
  parameter int D        = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         m0_req,
  input  logic         m0_rw,
  input  logic [A-1:0] m0_addr,
  input  logic [D-1:0] m0_wdata,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic [D-1:0] m0_rdata,
  input  logic         m1_req,
  input  logic         m1_rw,
  input  logic [A-1:0] m1_addr,
  input  logic [D-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic [D-1:0] m1_rdata,
  output logic         ram_cs,
  output logic         ram_rw,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_wdata,
  input  logic [D-1:0] ram_rdata,
  output logic [3:0]   wait_cnt,
  output logic [15:0]  force_cnt
);

  typedef enum logic [0:0] {
    PRI0   = 1'b0,
    FORCE1 = 1'b1
  } state_t;

  // Port 1 is forced once the wait count about to be stored reaches this value,
  // so the forced grant lands on its MAX_WAIT-th waiting cycle.
  localparam logic [4:0] FORCE_AT = 5'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] force_cnt_q, force_cnt_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;
  logic        gnt0, gnt1;

  // Arbitration, starvation counting and next-state; nothing is granted while in reset
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    state_d     = PRI0;
    wait_cnt_d  = 4'd0;
    force_cnt_d = force_cnt_q;
    rv0_d       = 1'b0;
    rv1_d       = 1'b0;
    if (!reset) begin
      if (state_q == FORCE1) begin
        if (m1_req) begin
          gnt1        = 1'b1;
          force_cnt_d = force_cnt_q + 16'd1;
        end else if (m0_req) begin
          gnt0 = 1'b1;
        end
      end else begin
        if (m0_req) begin
          gnt0 = 1'b1;
        end else if (m1_req) begin
          gnt1 = 1'b1;
        end
      end

      if (m1_req && !gnt1) begin
        wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
      end

      if (state_q == PRI0 && m1_req && !gnt1 && {1'b0, wait_cnt_d} >= FORCE_AT) begin
        state_d = FORCE1;
      end

      rv0_d = gnt0 & m0_rw;
      rv1_d = gnt1 & m1_rw;
    end
  end

  // State, counters and the one-cycle read-return tags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PRI0;
      wait_cnt_q  <= 4'd0;
      force_cnt_q <= 16'd0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      force_cnt_q <= force_cnt_d;
      rv0_q       <= rv0_d;
      rv1_q       <= rv1_d;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  assign ram_cs    = gnt0 | gnt1;
  assign ram_rw    = gnt0 ? m0_rw    : (gnt1 ? m1_rw    : 1'b1);
  assign ram_addr  = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
  assign ram_wdata = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);

  // A read tagged just before reset must not surface while reset is held.
  assign m0_rvalid = rv0_q & ~reset;
  assign m1_rvalid = rv1_q & ~reset;
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

  assign wait_cnt  = wait_cnt_q;
  assign force_cnt = force_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int A  = 12;
  localparam int D  = 8;
  localparam int MW = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic        port;
    logic        rw;
    logic [11:0] addr;
    logic [7:0]  wd;
  } acc_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  data;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         m0_req, m0_rw, m1_req, m1_rw;
  logic [A-1:0] m0_addr, m1_addr;
  logic [D-1:0] m0_wdata, m1_wdata;
  logic         m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [D-1:0] m0_rdata, m1_rdata;
  logic         ram_cs, ram_rw;
  logic [A-1:0] ram_addr;
  logic [D-1:0] ram_wdata;
  logic [D-1:0] ram_rdata = '0;
  logic [3:0]   wait_cnt;
  logic [15:0]  force_cnt;

  mem_arbiter #(.A(A), .D(D), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .wait_cnt(wait_cnt), .force_cnt(force_cnt)
  );

  logic [7:0] mem [0:4095];

  // RAM model with one-cycle registered read
  always @(posedge clk) begin
    if (ram_cs && !ram_rw) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_rw)  ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_err = 0;
  acc_t exp_acc[$];
  rd_t  exp_rd0[$];
  rd_t  exp_rd1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic rw, input logic [11:0] addr, input logic [7:0] wd);
    m0_req = req; m0_rw = rw; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic rw, input logic [11:0] addr, input logic [7:0] wd);
    m1_req = req; m1_rw = rw; m1_addr = addr; m1_wdata = wd;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b1, 12'h000, 8'h00);
    set_m1(1'b0, 1'b1, 12'h000, 8'h00);
  endtask

  task automatic expect_access(input logic port, input logic rw, input logic [11:0] addr,
                               input logic [7:0] wd, input logic want_rv, input logic [7:0] rd);
    acc_t a;
    rd_t  r;
    a.cyc = 32'(cyc); a.port = port; a.rw = rw; a.addr = addr; a.wd = wd;
    exp_acc.push_back(a);
    if (want_rv) begin
      r.cyc = 32'(cyc + 1); r.data = rd;
      if (port) exp_rd1.push_back(r);
      else      exp_rd0.push_back(r);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an access or a read return
  always @(negedge clk) begin
    acc_t a;
    rd_t  r;
    chk("gnt_exclusive", 64'(m0_gnt & m1_gnt), 64'd0);
    if (ram_cs) begin
      if (exp_acc.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_access: got port1=%0b addr=%h at cycle %0d, expected none", m1_gnt, ram_addr, cyc);
      end else begin
        a = exp_acc.pop_front();
        chk("access", 64'({32'(cyc), m1_gnt, ram_rw, ram_addr, ram_wdata}), 64'(a));
      end
    end
    if (m0_rvalid) begin
      if (exp_rd0.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_m0_rvalid: got rdata=%h at cycle %0d, expected none", m0_rdata, cyc);
      end else begin
        r = exp_rd0.pop_front();
        chk("m0_read", 64'({32'(cyc), m0_rdata}), 64'(r));
      end
    end else begin
      chk("m0_rdata_zero", 64'(m0_rdata), 64'd0);
    end
    if (m1_rvalid) begin
      if (exp_rd1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_m1_rvalid: got rdata=%h at cycle %0d, expected none", m1_rdata, cyc);
      end else begin
        r = exp_rd1.pop_front();
        chk("m1_read", 64'({32'(cyc), m1_rdata}), 64'(r));
      end
    end else begin
      chk("m1_rdata_zero", 64'(m1_rdata), 64'd0);
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h005] = 8'hA5;
    mem[12'h020] = 8'h11;
    mem[12'h021] = 8'h22;
    mem[12'h030] = 8'h5C;

    reset = 1'b1;
    idle();
    set_m0(1'b1, 1'b1, 12'h005, 8'h00);
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
      chk("rst_ram_cs", 64'(ram_cs), 64'd0);
      chk("rst_wait", 64'(wait_cnt), 64'd0);
      chk("rst_force", 64'(force_cnt), 64'd0);
    end

    // single m0 read, granted on the first cycle out of reset
    next_cycle(); reset = 1'b0;
    set_m0(1'b1, 1'b1, 12'h005, 8'h00);
    expect_access(1'b0, 1'b1, 12'h005, 8'h00, 1'b1, 8'hA5);
    @(negedge clk);
    chk("t1_wait", 64'(wait_cnt), 64'd0);

    next_cycle(); idle();
    @(negedge clk);
    chk("idle_ram_rw", 64'(ram_rw), 64'd1);
    chk("idle_ram_addr", 64'(ram_addr), 64'd0);
    chk("idle_ram_wdata", 64'(ram_wdata), 64'd0);

    // m1 write with m0 idle
    next_cycle();
    set_m1(1'b1, 1'b0, 12'h010, 8'h3C);
    expect_access(1'b1, 1'b0, 12'h010, 8'h3C, 1'b0, 8'h00);
    next_cycle(); idle();

    // alternating back-to-back reads, then read back the write
    next_cycle();
    set_m0(1'b1, 1'b1, 12'h020, 8'h00);
    expect_access(1'b0, 1'b1, 12'h020, 8'h00, 1'b1, 8'h11);
    next_cycle();
    set_m0(1'b0, 1'b1, 12'h000, 8'h00);
    set_m1(1'b1, 1'b1, 12'h021, 8'h00);
    expect_access(1'b1, 1'b1, 12'h021, 8'h00, 1'b1, 8'h22);
    next_cycle();
    set_m1(1'b0, 1'b1, 12'h000, 8'h00);
    set_m0(1'b1, 1'b1, 12'h010, 8'h00);
    expect_access(1'b0, 1'b1, 12'h010, 8'h00, 1'b1, 8'h3C);
    next_cycle(); idle();

    // both request continuously: m1 forced every fourth cycle
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      set_m0(1'b1, 1'b1, 12'h030, 8'h00);
      set_m1(1'b1, 1'b1, 12'h021, 8'h00);
      if (k % 4 == 3) expect_access(1'b1, 1'b1, 12'h021, 8'h00, 1'b1, 8'h22);
      else            expect_access(1'b0, 1'b1, 12'h030, 8'h00, 1'b1, 8'h5C);
      @(negedge clk);
      chk("cont_wait", 64'(wait_cnt), 64'(k % 4));
      chk("cont_force", 64'(force_cnt), 64'(k / 4));
    end
    next_cycle(); idle();
    @(negedge clk);
    chk("cont_force_end", 64'(force_cnt), 64'd2);
    chk("cont_wait_end", 64'(wait_cnt), 64'd0);

    // m1 drops its request exactly in the forced cycle
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      set_m0(1'b1, 1'b1, 12'h030, 8'h00);
      set_m1((k == 3) ? 1'b0 : 1'b1, 1'b1, 12'h021, 8'h00);
      expect_access(1'b0, 1'b1, 12'h030, 8'h00, 1'b1, 8'h5C);
      @(negedge clk);
      chk("drop_wait", 64'(wait_cnt), (k < 4) ? 64'(k) : 64'd0);
      chk("drop_force", 64'(force_cnt), 64'd2);
    end
    next_cycle(); idle();
    @(negedge clk);
    chk("drop_force_end", 64'(force_cnt), 64'd2);
    chk("drop_wait_end", 64'(wait_cnt), 64'd1);

    // reset right after an m1 read grant: no read return, requests ignored
    next_cycle();
    set_m1(1'b1, 1'b1, 12'h021, 8'h00);
    expect_access(1'b1, 1'b1, 12'h021, 8'h00, 1'b0, 8'h00);
    next_cycle(); reset = 1'b1;
    set_m1(1'b0, 1'b1, 12'h000, 8'h00);
    set_m0(1'b1, 1'b1, 12'h005, 8'h00);
    @(negedge clk);
    chk("rst2_m1_rvalid", 64'(m1_rvalid), 64'd0);
    chk("rst2_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("rst2_ram_cs", 64'(ram_cs), 64'd0);
    chk("rst2_wait", 64'(wait_cnt), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("rst2_force", 64'(force_cnt), 64'd0);
    chk("rst2_m0_rvalid", 64'(m0_rvalid), 64'd0);
    next_cycle(); reset = 1'b0;
    expect_access(1'b0, 1'b1, 12'h005, 8'h00, 1'b1, 8'hA5);

    // preload the forced-grant counter to its top and wrap it with one forced write
    next_cycle(); idle();
    force dut.force_cnt_q = 16'hFFFF;
    next_cycle();
    release dut.force_cnt_q;
    @(negedge clk);
    chk("preload_force", 64'(force_cnt), 64'hFFFF);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_m0(1'b1, 1'b0, 12'h040, 8'h77);
      set_m1(1'b1, 1'b0, 12'h041, 8'h88);
      if (k == 3) expect_access(1'b1, 1'b0, 12'h041, 8'h88, 1'b0, 8'h00);
      else        expect_access(1'b0, 1'b0, 12'h040, 8'h77, 1'b0, 8'h00);
    end
    next_cycle(); idle();
    @(negedge clk);
    chk("wrap_force", 64'(force_cnt), 64'd0);
    chk("wrap_wait", 64'(wait_cnt), 64'd0);

    next_cycle();
    set_m0(1'b1, 1'b1, 12'h041, 8'h00);
    expect_access(1'b0, 1'b1, 12'h041, 8'h00, 1'b1, 8'h88);
    next_cycle();
    set_m0(1'b1, 1'b1, 12'h040, 8'h00);
    expect_access(1'b0, 1'b1, 12'h040, 8'h00, 1'b1, 8'h77);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk);
    chk("pending_access", 64'(exp_acc.size()), 64'd0);
    chk("pending_rd0", 64'(exp_rd0.size()), 64'd0);
    chk("pending_rd1", 64'(exp_rd1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
